instr_streamer: RTL and testbench
=================================

# instr_streamer

Instruction source for the `cpu` core's `INSTRUCTION`/`write_en` port. It collects 9-bit instruction words from a 3-bit chunked loader interface into an on-chip program buffer. On command it replays the buffer to the core, one word per clock, with a `write_en` strobe. It sits between the chip input pins and the core and replaces direct pin drive of `INSTRUCTION`.

## Interface
- `DEPTH`, default 8: number of program buffer entries. Must be a power of two.
- `AW`, default 3: pointer width. Must equal log2(`DEPTH`).
- `CLK`  input  1: clock, rising edge.
- `RESET`  input  1: asynchronous, active-high.
- `LD_DATA`  input  3: instruction chunk, most significant chunk first.
- `LD_VALID`  input  1: `LD_DATA` is valid this cycle. One chunk is accepted per cycle while high.
- `CLEAR`  input  1: empties the buffer. Honoured in IDLE only.
- `START`  input  1: begin playback. Honoured in IDLE only.
- `LOOP`  input  1: sampled at wrap. When high, playback restarts at entry 0.
- `HALT`  input  1: abort playback.
- `INSTRUCTION`  output  9: word presented to the core. Registered.
- `write_en`  output  1: `INSTRUCTION` is valid for the core this cycle. Registered.
- `BUSY`  output  1: high while in PLAY.
- `COUNT`  output  AW+1: number of complete words stored, 0..`DEPTH`.
- `OVERFLOW`  output  1: sticky. Set when a word completes while the buffer is full. Cleared by `CLEAR` or `RESET`.

## Operation
- Reset values:
  - `INSTRUCTION` = 0, `write_en` = 0, `BUSY` = 0, `COUNT` = 0, `OVERFLOW` = 0.
  - State = IDLE; write pointer, read pointer and chunk counter = 0.
  - Buffer contents are not reset.
- States:
  - IDLE: loading and command acceptance.
  - PLAY: streaming to the core.
- Chunk assembly (IDLE, `LD_VALID`=1):
  - Chunk counter 0 → `LD_DATA` goes to bits [8:6].
  - Chunk counter 1 → bits [5:3].
  - Chunk counter 2 → bits [2:0], and the word is complete. The chunk counter wraps 2→0.
- Word completion:
  - If `COUNT` < `DEPTH`: word written to `buf[wr_ptr]`, `wr_ptr`++, `COUNT`++.
  - If `COUNT` == `DEPTH`: word discarded, `OVERFLOW` set, `COUNT` and `wr_ptr` unchanged.
- `CLEAR` (IDLE):
  - `COUNT`, `wr_ptr`, chunk counter and `OVERFLOW` → 0.
  - `CLEAR` has priority over `LD_VALID` in the same cycle.
- `START` (IDLE, not `CLEAR`):
  - With `COUNT` > 0: discards any partial word (chunk counter → 0), enters PLAY.
  - With `COUNT` = 0: ignored; the partial word is retained.
  - If `START` and `LD_VALID` are both high in IDLE, `START` wins and the chunk is dropped.
- PLAY:
  - Each cycle presents `buf[rd_ptr]` with `write_en`=1, then `rd_ptr`++.
  - When `rd_ptr` reaches `COUNT`-1 and that word is issued, the block checks `LOOP`:
    - `LOOP`=1: `rd_ptr` → 0, stay in PLAY.
    - `LOOP`=0: return to IDLE.
  - `LD_VALID`, `CLEAR` and `START` are ignored in PLAY.
- `HALT` in PLAY: return to IDLE at the next edge. `HALT` in IDLE: no effect.
- `INSTRUCTION` holds its last value whenever `write_en`=0.

## Timing
- `START` sampled high at edge k, `COUNT`=N:
  - At edge k: `BUSY`=1, `write_en`=1, `INSTRUCTION`=`buf[0]`.
  - At edge k+j (j < N): `INSTRUCTION`=`buf[j]`.
  - At edge k+N, `LOOP`=0: `write_en`=0, `BUSY`=0.
  - Result: `write_en` is high for exactly N cycles per pass.
- With `LOOP`=1 sampled at edge k+N-1: edge k+N presents `buf[0]` again with no gap cycle.
- `HALT` sampled high at edge m in PLAY:
  - `write_en`=0 and `BUSY`=0 at edge m.
  - No further word is issued.
  - `HALT` has priority over the wrap/`LOOP` decision.
- Third chunk sampled at edge k: `COUNT` increments at edge k. A `START` at edge k+1 includes the new word.
- N=1 with `LOOP`=1: the same word is issued every cycle.
- `RESET` asserted mid-PLAY: all outputs go to reset values immediately, without waiting for a clock edge.

## Test plan
- Load 0x1A5 as chunks 3'b110, 3'b100, 3'b101 → `COUNT`=1. Then `START` → exactly one cycle with `write_en`=1, `INSTRUCTION`=0x1A5. Then `BUSY`=0.
- Load 3 words 0x001, 0x0F0, 0x1FF, `LOOP`=0, `START` → 3 consecutive `write_en` cycles in that order. `write_en`=0 on the 4th cycle.
- Load 2 words 0x011 and 0x022, `LOOP`=1 → sequence 0x011, 0x022, 0x011, 0x022. Assert `HALT` during the 3rd issued word → `write_en` low from that edge, `INSTRUCTION` holds 0x011.
- Load 9 words with `DEPTH`=8 → `COUNT`=8, `OVERFLOW`=1. The 9th word is never issued. `CLEAR` → `COUNT`=0, `OVERFLOW`=0.
- Load 1 word plus 2 chunks, then `START` → one word is played. Reload 3 chunks 0,0,7 → stored word is 0x007, not misaligned.
- `START` with `COUNT`=0 → `write_en` stays 0. Assert `RESET` mid-PLAY → `write_en`, `BUSY` and `COUNT` are 0 immediately.

Source files
------------

// File: rtl/instr_streamer_if.sv
// -----------------------------------------------------------------------------
// instr_streamer_if: loader/command inputs and core-facing outputs. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface instr_streamer_if #(
  parameter int AW = 3
);
  logic [2:0]  LD_DATA;
  logic        LD_VALID;
  logic        CLEAR;
  logic        START;
  logic        LOOP;
  logic        HALT;
  logic [8:0]  INSTRUCTION;
  logic        write_en;
  logic        BUSY;
  logic [AW:0] COUNT;
  logic        OVERFLOW;

  modport master (
    output LD_DATA, LD_VALID, CLEAR, START, LOOP, HALT,
    input  INSTRUCTION, write_en, BUSY, COUNT, OVERFLOW
  );

  modport slave (
    input  LD_DATA, LD_VALID, CLEAR, START, LOOP, HALT,
    output INSTRUCTION, write_en, BUSY, COUNT, OVERFLOW
  );
endinterface

`default_nettype wire

// File: rtl/instr_streamer.sv
// -----------------------------------------------------------------------------
// instr_streamer: assembles 3-bit chunks into a 9-bit program buffer and
// replays it to the core one word per clock. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module instr_streamer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  instr_streamer_if.slave   bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_PLAY = 1'b1
  } state_t;

  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]    chunk_q, chunk_d;
  logic [5:0]    asm_q, asm_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [8:0]    instr_q, instr_d;
  logic          we_q, we_d;
  logic          done_q, done_d;

  logic [8:0]    mem_q [DEPTH];
  logic          mem_we;
  logic [8:0]    mem_wdata;
  logic          issue;
  logic [AW-1:0] issue_idx;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      chunk_q  <= '0;
      asm_q    <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      instr_q  <= '0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      chunk_q  <= chunk_d;
      asm_q    <= asm_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      instr_q  <= instr_d;
      we_q     <= we_d;
      done_q   <= done_d;
    end
  end

  // Program storage is deliberately not reset.
  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[wr_ptr_q] <= mem_wdata;
  end

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    chunk_d   = chunk_q;
    asm_d     = asm_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    instr_d   = instr_q;
    we_d      = 1'b0;
    done_d    = done_q;
    mem_we    = 1'b0;
    mem_wdata = {asm_q, bus.LD_DATA};
    issue     = 1'b0;
    issue_idx = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.CLEAR) begin
          wr_ptr_d = '0;
          count_d  = '0;
          chunk_d  = '0;
          ovf_d    = 1'b0;
        end else if (bus.START) begin
          // An empty buffer ignores START but still swallows any chunk.
          if (count_q != '0) begin
            chunk_d   = '0;
            state_d   = S_PLAY;
            issue     = 1'b1;
            issue_idx = '0;
          end
        end else if (bus.LD_VALID) begin
          case (chunk_q)
            2'd0: begin
              asm_d[5:3] = bus.LD_DATA;
              chunk_d    = 2'd1;
            end
            2'd1: begin
              asm_d[2:0] = bus.LD_DATA;
              chunk_d    = 2'd2;
            end
            default: begin
              chunk_d = 2'd0;
              if (count_q != C_FULL) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                count_d  = count_q + 1'b1;
              end else begin
                ovf_d = 1'b1;
              end
            end
          endcase
        end
      end
      default: begin
        if (bus.HALT || done_q) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end else begin
          issue     = 1'b1;
          issue_idx = rd_ptr_q;
        end
      end
    endcase

    // The wrap decision is taken on the edge that issues the last word.
    if (issue) begin
      instr_d = mem_q[issue_idx];
      we_d    = 1'b1;
      if ({1'b0, issue_idx} == count_q - 1'b1) begin
        rd_ptr_d = '0;
        if (!bus.LOOP) done_d = 1'b1;
      end else begin
        rd_ptr_d = issue_idx + 1'b1;
      end
    end
  end

  assign bus.INSTRUCTION = instr_q;
  assign bus.write_en    = we_q;
  assign bus.BUSY        = (state_q == S_PLAY);
  assign bus.COUNT       = count_q;
  assign bus.OVERFLOW    = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_streamer.sv
// -----------------------------------------------------------------------------
// tb_instr_streamer: randomized scenarios against a word-queue program model. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_instr_streamer;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic CLK;
  logic RESET;
  int   total;
  int   bad;

  logic [8:0] model_q [$];
  bit         model_ovf;

  instr_streamer_if #(.AW(AW)) bus ();

  instr_streamer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_clear();
    bus.CLEAR = 1'b1;
    step();
    bus.CLEAR = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
  endtask

  task automatic send_chunk(input logic [2:0] c);
    bus.LD_VALID = 1'b1;
    bus.LD_DATA  = c;
    step();
    bus.LD_VALID = 1'b0;
  endtask

  task automatic load_word(input logic [8:0] w);
    send_chunk(w[8:6]);
    send_chunk(w[5:3]);
    send_chunk(w[2:0]);
    if (model_q.size() < DEPTH) model_q.push_back(w);
    else                        model_ovf = 1'b1;
    total++;
    if (bus.COUNT !== 4'(model_q.size())) begin
      bad++;
      $display("FAIL load_count: got %0d want %0d", bus.COUNT, model_q.size());
    end
  endtask

  // One START with LOOP low: every stored word once, then write_en drops.
  task automatic play_once();
    int n;
    n = model_q.size();
    bus.LOOP  = 1'b0;
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    for (int j = 0; j < n; j++) begin
      total++;
      if (bus.write_en !== 1'b1 || bus.BUSY !== 1'b1 || bus.INSTRUCTION !== model_q[j]) begin
        bad++;
        $display("FAIL play_word%0d: got we=%b busy=%b instr=%h want we=1 busy=1 instr=%h",
                 j, bus.write_en, bus.BUSY, bus.INSTRUCTION, model_q[j]);
      end
      if (j < n - 1) step();
    end
    step();
    total++;
    if (bus.write_en !== 1'b0 || bus.BUSY !== 1'b0 || bus.INSTRUCTION !== model_q[n-1]) begin
      bad++;
      $display("FAIL play_end: got we=%b busy=%b instr=%h want we=0 busy=0 instr=%h",
               bus.write_en, bus.BUSY, bus.INSTRUCTION, model_q[n-1]);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    #3;
    total++;
    if (bus.INSTRUCTION !== 9'h0 || bus.write_en !== 1'b0 || bus.BUSY !== 1'b0 ||
        bus.COUNT !== 4'd0 || bus.OVERFLOW !== 1'b0) begin
      bad++;
      $display("FAIL reset: got instr=%h we=%b busy=%b count=%0d ovf=%b want all zero",
               bus.INSTRUCTION, bus.write_en, bus.BUSY, bus.COUNT, bus.OVERFLOW);
    end
    step();
    RESET = 1'b0;
    step();
  endtask

  task automatic test_single();
    do_clear();
    send_chunk(3'b110);
    send_chunk(3'b100);
    send_chunk(3'b101);
    model_q.push_back(9'h1A5);
    total++;
    if (bus.COUNT !== 4'd1) begin
      bad++;
      $display("FAIL single_count: got %0d want 1", bus.COUNT);
    end
    play_once();
  endtask

  task automatic test_three();
    do_clear();
    load_word(9'h001);
    load_word(9'h0F0);
    load_word(9'h1FF);
    play_once();
  endtask

  task automatic test_loop_halt();
    logic [8:0] seq [3];
    do_clear();
    load_word(9'h011);
    load_word(9'h022);
    seq[0] = 9'h011; seq[1] = 9'h022; seq[2] = 9'h011;
    bus.LOOP  = 1'b1;
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (bus.write_en !== 1'b1 || bus.INSTRUCTION !== seq[i]) begin
        bad++;
        $display("FAIL loop_word%0d: got we=%b instr=%h want we=1 instr=%h",
                 i, bus.write_en, bus.INSTRUCTION, seq[i]);
      end
      if (i < 2) step();
    end
    bus.HALT = 1'b1;
    step();
    bus.HALT = 1'b0;
    bus.LOOP = 1'b0;
    total++;
    if (bus.write_en !== 1'b0 || bus.BUSY !== 1'b0 || bus.INSTRUCTION !== 9'h011) begin
      bad++;
      $display("FAIL halt: got we=%b busy=%b instr=%h want we=0 busy=0 instr=011",
               bus.write_en, bus.BUSY, bus.INSTRUCTION);
    end
    step();
    total++;
    if (bus.write_en !== 1'b0) begin
      bad++;
      $display("FAIL halt_stays: got we=%b want 0", bus.write_en);
    end
  endtask

  task automatic test_overflow();
    do_clear();
    for (int i = 0; i < DEPTH + 1; i++) load_word(9'($urandom_range(0, 511)));
    total++;
    if (bus.COUNT !== 4'(DEPTH) || bus.OVERFLOW !== model_ovf) begin
      bad++;
      $display("FAIL overflow: got count=%0d ovf=%b want count=%0d ovf=%b",
               bus.COUNT, bus.OVERFLOW, DEPTH, model_ovf);
    end
    play_once();
    do_clear();
    total++;
    if (bus.COUNT !== 4'd0 || bus.OVERFLOW !== 1'b0) begin
      bad++;
      $display("FAIL overflow_clear: got count=%0d ovf=%b want 0 0", bus.COUNT, bus.OVERFLOW);
    end
  endtask

  task automatic test_partial();
    do_clear();
    load_word(9'($urandom_range(0, 511)));
    send_chunk(3'($urandom_range(0, 7)));
    send_chunk(3'($urandom_range(0, 7)));
    play_once();
    load_word(9'h007);
    play_once();
  endtask

  task automatic test_empty_start();
    do_clear();
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (bus.write_en !== 1'b0 || bus.BUSY !== 1'b0) begin
        bad++;
        $display("FAIL empty_start: got we=%b busy=%b want 0 0", bus.write_en, bus.BUSY);
      end
      step();
    end
  endtask

  task automatic test_loop_random();
    int n;
    int p;
    for (int r = 0; r < 4; r++) begin
      do_clear();
      n = (r == 0) ? 1 : $urandom_range(1, DEPTH);
      p = $urandom_range(2, 3);
      for (int i = 0; i < n; i++) load_word(9'($urandom_range(0, 511)));
      bus.LOOP  = 1'b1;
      bus.START = 1'b1;
      step();
      bus.START = 1'b0;
      for (int i = 0; i < n * p; i++) begin
        total++;
        if (bus.write_en !== 1'b1 || bus.INSTRUCTION !== model_q[i % n]) begin
          bad++;
          $display("FAIL loop_rand r%0d i%0d: got we=%b instr=%h want we=1 instr=%h",
                   r, i, bus.write_en, bus.INSTRUCTION, model_q[i % n]);
        end
        if (i < n * p - 1) step();
      end
      bus.HALT = 1'b1;
      step();
      bus.HALT = 1'b0;
      bus.LOOP = 1'b0;
      total++;
      if (bus.write_en !== 1'b0 || bus.BUSY !== 1'b0 || bus.INSTRUCTION !== model_q[n-1]) begin
        bad++;
        $display("FAIL loop_rand_halt r%0d: got we=%b busy=%b instr=%h want 0 0 %h",
                 r, bus.write_en, bus.BUSY, bus.INSTRUCTION, model_q[n-1]);
      end
    end
  endtask

  task automatic test_play_random();
    for (int r = 0; r < 4; r++) begin
      do_clear();
      for (int i = 0; i < $urandom_range(1, DEPTH); i++) load_word(9'($urandom_range(0, 511)));
      play_once();
    end
  endtask

  task automatic test_reset_mid_play();
    do_clear();
    for (int i = 0; i < 4; i++) load_word(9'($urandom_range(0, 511)));
    bus.LOOP  = 1'b1;
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    step();
    RESET = 1'b1;
    #2;
    total++;
    if (bus.write_en !== 1'b0 || bus.BUSY !== 1'b0 || bus.COUNT !== 4'd0 ||
        bus.INSTRUCTION !== 9'h0) begin
      bad++;
      $display("FAIL reset_mid_play: got we=%b busy=%b count=%0d instr=%h want all zero",
               bus.write_en, bus.BUSY, bus.COUNT, bus.INSTRUCTION);
    end
    bus.LOOP = 1'b0;
    step();
    RESET = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
    step();
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    model_ovf    = 1'b0;
    RESET        = 1'b1;
    bus.LD_DATA  = '0;
    bus.LD_VALID = 1'b0;
    bus.CLEAR    = 1'b0;
    bus.START    = 1'b0;
    bus.LOOP     = 1'b0;
    bus.HALT     = 1'b0;

    test_reset();
    test_single();
    test_three();
    test_loop_halt();
    test_overflow();
    test_partial();
    test_empty_start();
    test_loop_random();
    test_play_random();
    test_reset_mid_play();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
